// File: rtl/ram_sweep_ctrl_if.sv
// Bus between the sweep controller and its environment: RAM address/strobe,
// read data coming back, control handshakes and the accumulated results.
interface ram_sweep_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic              start;
    logic              abort;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] a;
    logic              we;
    logic              busy;
    logic              done;
    logic [7:0]        sum;
    logic [4:0]        ones;
    logic [DATA_W-1:0] max;

    modport master (
        input  start, abort, rd_data,
        output a, we, busy, done, sum, ones, max
    );

    modport slave (
        output start, abort, rd_data,
        input  a, we, busy, done, sum, ones, max
    );
endinterface

// File: rtl/ram_sweep_ctrl.sv
// Write-then-read RAM sweep controller: 2**ADDR_W writes, then 2**ADDR_W reads
// accumulating sum, count of odd words and maximum, then a one-cycle DONE.
module ram_sweep_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_sweep_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] a_reg, a_next;
    logic              we_reg, we_next;
    logic [7:0]        sum_reg, sum_next;
    logic [4:0]        ones_reg, ones_next;
    logic [DATA_W-1:0] max_reg, max_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            we_reg    <= 1'b0;
            sum_reg   <= '0;
            ones_reg  <= '0;
            max_reg   <= '0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            we_reg    <= we_next;
            sum_reg   <= sum_next;
            ones_reg  <= ones_next;
            max_reg   <= max_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        we_next    = we_reg;
        sum_next   = sum_reg;
        ones_next  = ones_reg;
        max_next   = max_reg;

        case (state_reg)
            IDLE: begin
                // abort wins over start, and results from the last sweep are kept
                if (bus.start && !bus.abort) begin
                    state_next = WRITE;
                    a_next     = '0;
                    we_next    = 1'b1;
                    sum_next   = '0;
                    ones_next  = '0;
                    max_next   = '0;
                end
            end

            WRITE: begin
                if (bus.abort) begin
                    state_next = IDLE;
                    a_next     = '0;
                    we_next    = 1'b0;
                    sum_next   = '0;
                    ones_next  = '0;
                    max_next   = '0;
                end else if (a_reg == LAST_ADDR) begin
                    state_next = READ;
                    a_next     = '0;
                    we_next    = 1'b0;
                end else begin
                    a_next = a_reg + 1'b1;
                end
            end

            READ: begin
                if (bus.abort) begin
                    state_next = IDLE;
                    a_next     = '0;
                    we_next    = 1'b0;
                    sum_next   = '0;
                    ones_next  = '0;
                    max_next   = '0;
                end else begin
                    sum_next  = sum_reg + 8'(bus.rd_data);
                    ones_next = ones_reg + 5'(bus.rd_data[0]);
                    if (bus.rd_data > max_reg) begin
                        max_next = bus.rd_data;
                    end
                    if (a_reg == LAST_ADDR) begin
                        state_next = FIN;
                        a_next     = '0;
                    end else begin
                        a_next = a_reg + 1'b1;
                    end
                end
            end

            FIN: begin
                state_next = IDLE;
                we_next    = 1'b0;
            end

            default: begin
                state_next = IDLE;
                a_next     = '0;
                we_next    = 1'b0;
            end
        endcase
    end

    // Status flags decode straight from the state so reset clears them at once.
    assign bus.busy = (state_reg == WRITE) || (state_reg == READ);
    assign bus.done = (state_reg == FIN);
    assign bus.a    = a_reg;
    assign bus.we   = we_reg;
    assign bus.sum  = sum_reg;
    assign bus.ones = ones_reg;
    assign bus.max  = max_reg;

endmodule

// File: tb/tb_ram_sweep_ctrl.sv
// Directed bench for ram_sweep_ctrl with a small RAM model whose write data
// is a selectable function of the address.
module tb_ram_sweep_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   mode = 0;

    always #5 clk = ~clk;

    ram_sweep_ctrl_if #(.ADDR_W(4), .DATA_W(4)) bus();

    ram_sweep_ctrl #(.ADDR_W(4), .DATA_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [3:0] mem [16];

    function automatic logic [3:0] wr_pattern(input logic [3:0] addr);
        case (mode)
            0:       return 4'hF;
            1:       return addr;
            default: return 4'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.we) mem[bus.a] <= wr_pattern(bus.a);
    end

    assign bus.rd_data = mem[bus.a];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_a"},    32'(bus.a),    0);
        check({tag, "_we"},   32'(bus.we),   0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_done"}, 32'(bus.done), 0);
        check({tag, "_sum"},  32'(bus.sum),  0);
        check({tag, "_ones"}, 32'(bus.ones), 0);
        check({tag, "_max"},  32'(bus.max),  0);
    endtask

    // Starts a sweep at the next rising edge (edge 0) and checks cycles 1..35.
    task automatic sweep(input string tag, input int m, input int abort_cyc, input bit hold,
                         input int exp_sum, input int exp_ones, input int exp_max);
        int  done_cnt;
        int  ea, ewe, ebusy, edone;
        bit  aborted;
        done_cnt = 0;
        mode = m;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.start = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            aborted = (abort_cyc > 0) && (k > abort_cyc);
            ea = 0; ewe = 0; ebusy = 0; edone = 0;
            if (!aborted) begin
                if (k <= 16) begin
                    ea = k - 1; ewe = 1; ebusy = 1;
                end else if (k <= 32) begin
                    ea = k - 17; ebusy = 1;
                end else if (k == 33) begin
                    edone = 1;
                end else if (k == 35 && hold) begin
                    ewe = 1; ebusy = 1;
                end
            end
            check({tag, "_a"},    32'(bus.a),    ea);
            check({tag, "_we"},   32'(bus.we),   ewe);
            check({tag, "_busy"}, 32'(bus.busy), ebusy);
            check({tag, "_done"}, 32'(bus.done), edone);
            if (bus.done === 1'b1) done_cnt++;
            if (aborted || k == 1 || (k == 35 && hold)) begin
                check({tag, "_sum_clr"},  32'(bus.sum),  0);
                check({tag, "_ones_clr"}, 32'(bus.ones), 0);
                check({tag, "_max_clr"},  32'(bus.max),  0);
            end else if (k == 33 || k == 34) begin
                check({tag, "_sum"},  32'(bus.sum),  exp_sum);
                check({tag, "_ones"}, 32'(bus.ones), exp_ones);
                check({tag, "_max"},  32'(bus.max),  exp_max);
            end
            bus.abort = (k == abort_cyc);
        end
        bus.start = 1'b0;
        if (hold) begin
            bus.abort = 1'b1;
            @(negedge clk);
            bus.abort = 1'b0;
            check({tag, "_end_busy"}, 32'(bus.busy), 0);
            check({tag, "_end_a"},    32'(bus.a),    0);
        end
        $display("sweep %s mode=%0d abort_cyc=%0d hold=%0d done_pulses=%0d sum=%0d ones=%0d max=%0d",
                 tag, m, abort_cyc, hold, done_cnt, bus.sum, bus.ones, bus.max);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        rst_n = 1'b0;
        #1;
        check_idle_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        sweep("all_f", 0, 0, 1'b0, 240, 16, 15);
        sweep("addr",  1, 0, 1'b0, 120, 8, 15);

        // start and abort together in IDLE: stay idle, results untouched
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("idle_abort_busy", 32'(bus.busy), 0);
        check("idle_abort_we",   32'(bus.we),   0);
        check("idle_abort_sum",  32'(bus.sum),  120);
        @(negedge clk);
        check("idle_abort_busy2", 32'(bus.busy), 0);
        $display("idle start+abort busy=%0d sum=%0d", bus.busy, bus.sum);

        sweep("abort", 1, 20, 1'b0, 0, 0, 0);
        sweep("hold",  1, 0,  1'b1, 120, 8, 15);

        // reset pulse in the middle of WRITE, START already waiting on release
        mode = 1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_write_a", 32'(bus.a), 9);
        rst_n = 1'b0;
        #1;
        check_idle_zero("async_rst");
        $display("async reset mid-write a=%0d busy=%0d", bus.a, bus.busy);
        bus.start = 1'b1;
        #2;
        rst_n = 1'b1;
        sweep("zero", 2, 0, 1'b0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_sweep_ctrl.md
RAM_SWEEP_CTRL -- requirements
Module: ram_sweep_ctrl

Interface
REQ-001 Parameter: ADDR_W, 4, RAM address width; the sweep covers 2**ADDR_W = 16 words.
REQ-002 Parameter: DATA_W, 4, RAM data width.
REQ-003 CLK  in  1  single clock; all state changes on rising edge.
REQ-004 RST_N  in  1  asynchronous, active-low reset.
REQ-005 START  in  1  request a write-then-read sweep; sampled only in IDLE.
REQ-006 ABORT  in  1  synchronous abort; ends any active sweep.
REQ-007 DO  in  DATA_W  combinational read data returned by the RAM for address A.
REQ-008 A  out  ADDR_W  RAM address, registered.
REQ-009 WE  out  1  RAM write enable, registered; the RAM writes on the rising CLK edge when WE=1.
REQ-010 BUSY  out  1  high in WRITE and READ states.
REQ-011 DONE  out  1  one-cycle pulse when a sweep completes normally.
REQ-012 SUM  out  8  sum of all 16 words read back.
REQ-013 ONES  out  5  count of words read back with DO[0]=1.
REQ-014 MAX  out  DATA_W  largest word read back.

Function
REQ-015 FSM states SHALL be IDLE, WRITE, READ and FIN.
REQ-016 IDLE: START=1 at an edge SHALL give the next state WRITE with A=0, WE=1 and SUM/ONES/MAX cleared to 0.
REQ-017 WRITE: A SHALL increment by 1 per cycle with WE=1.
REQ-018 WRITE exit: the edge at which A=15 SHALL set A=0, WE=0 and state READ; exactly 16 writes occur.
REQ-019 READ: each edge SHALL accumulate DO at the current A into SUM (mod 256) and ONES, and update MAX if DO>MAX; A then increments.
REQ-020 READ exit: the edge at which A=15 SHALL perform the final accumulate and enter FIN with A=0.
REQ-021 FIN: DONE=1 for exactly one cycle; the next state SHALL be IDLE.
REQ-022 SUM, ONES and MAX SHALL hold their values from FIN until the next accepted START.
REQ-023 Timing: with START sampled at edge 0, cycles 1-16 SHALL be WRITE, cycles 17-32 READ, and DONE high in cycle 33.
REQ-024 START asserted in WRITE, READ or FIN SHALL be ignored; there is no queueing.
REQ-025 ABORT=1 in WRITE or READ SHALL give IDLE next cycle with WE=0, A=0, no DONE pulse, and SUM/ONES/MAX=0.
REQ-026 ABORT has priority over START when both are high in the same cycle; in IDLE the result is that IDLE is held.
REQ-027 WE SHALL never be high outside WRITE.
REQ-028 A SHALL never wrap past 15 within a single state.

Reset
REQ-029 RST_N=0 SHALL immediately, without a clock edge, force state IDLE and A=0, WE=0, BUSY=0, DONE=0, SUM=0, ONES=0, MAX=0.
REQ-030 Reset asserted mid-sweep SHALL abandon the sweep with no DONE pulse.
REQ-031 After RST_N rises, the first START SHALL be accepted at the first rising edge where RST_N=1.

Verification
REQ-032 Bench with RAM model, data written = 4'hF, START pulse -> DONE in cycle 33, SUM=240, ONES=16, MAX=15.
REQ-033 Data written = A, START -> SUM=120, ONES=8, MAX=15; WE high exactly cycles 1-16; A sequence 0..15 twice.
REQ-034 ABORT in cycle 20 (READ) -> IDLE in cycle 21, no DONE, SUM=ONES=MAX=0, BUSY=0.
REQ-035 START held high through the whole sweep -> single sweep, DONE pulses once in cycle 33, a new sweep starts from IDLE in cycle 34.
REQ-036 RST_N low for half a cycle in cycle 10 (WRITE) -> all outputs 0 immediately; a later START completes a normal sweep.
REQ-037 Data written = 4'h0 -> SUM=0, ONES=0, MAX=0, DONE still pulses in cycle 33.
